// File: rtl/noc_pkg.sv
// Shared definitions for the NoC credit-based link sender.
//   flit_t      : flit field layout {dest, is_tail, data}, shown at the default
//                 widths. Parameterised modules pack their words in this same
//                 field order.
//   pkt_state_e : packet-tracking FSM states {IDLE, IN_PKT}.
package noc_pkg;

  localparam int FLIT_WIDTH_DEFAULT = 128;
  localparam int DEST_WIDTH_DEFAULT = 4;

  typedef struct packed {
    logic [DEST_WIDTH_DEFAULT-1:0] dest;
    logic                          is_tail;
    logic [FLIT_WIDTH_DEFAULT-1:0] data;
  } flit_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } pkt_state_e;

  // Width of one packed flit word {dest, is_tail, data}.
  function automatic int flit_word_width(input int flit_width, input int dest_width);
    return dest_width + 1 + flit_width;
  endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Staging FIFO for outgoing flits.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push     : write wr_data (ignored while full)
//   pop      : drop the head entry (ignored while empty)
//   wr_data  : word to write
//   rd_data  : current head entry (valid while !empty)
//   full     : occupancy == DEPTH, derived from registered state only
//   empty    : occupancy == 0, derived from registered state only
module noc_flit_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNTW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset: contents are only observed through rd_ptr/count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/noc_credit_sender.sv
// Credit-based NoC link sender.
// Flits are staged in a small FIFO and launched onto the link only while the
// downstream buffer has a free slot (credit). Each launch consumes a credit;
// each credit_in pulse returns one.
//   clk_noc, rst_noc_sync       : clock, synchronous active-high reset
//   in_valid/in_ready           : upstream handshake (see below)
//   in_data, in_dest, in_is_tail: upstream flit
//   data_out, dest_out,
//   is_tail_out                 : registered link fields, hold between sends
//   send_out                    : one-cycle pulse per flit launched
//   credit_in                   : one-cycle pulse returning one slot
//   credits                     : current credit count
//   pkt_active                  : high from head flit sent to tail flit sent
//   credit_overflow             : sticky, a credit returned while already full
//
// Handshake: a flit transfers on every rising edge where in_valid and in_ready
// are both high. in_ready depends only on registered FIFO occupancy, never on
// in_valid or credit_in, and a pop on a full FIFO does not raise it early.
module noc_credit_sender
  import noc_pkg::*;
#(
  parameter int FLIT_WIDTH        = 128,
  parameter int DEST_WIDTH        = 4,
  parameter int FLIT_BUFFER_DEPTH = 1,
  parameter int IN_FIFO_DEPTH     = 2
) (
  input  logic                                   clk_noc,
  input  logic                                   rst_noc_sync,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [FLIT_WIDTH-1:0]                  in_data,
  input  logic [DEST_WIDTH-1:0]                  in_dest,
  input  logic                                   in_is_tail,
  output logic [FLIT_WIDTH-1:0]                  data_out,
  output logic [DEST_WIDTH-1:0]                  dest_out,
  output logic                                   is_tail_out,
  output logic                                   send_out,
  input  logic                                   credit_in,
  output logic [$clog2(FLIT_BUFFER_DEPTH+1)-1:0] credits,
  output logic                                   pkt_active,
  output logic                                   credit_overflow
);

  localparam int CW = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam int WORD_W = flit_word_width(FLIT_WIDTH, DEST_WIDTH);
  localparam logic [CW-1:0] MAX_CREDITS = CW'(FLIT_BUFFER_DEPTH);

  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              launch;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_word;
  logic [FLIT_WIDTH-1:0] rd_data;
  logic [DEST_WIDTH-1:0] rd_dest;
  logic              rd_tail;
  logic [CW-1:0]     credit_cnt;
  pkt_state_e        state;
  pkt_state_e        state_nxt;

  assign in_ready = ~fifo_full;
  assign push     = in_valid & ~fifo_full;
  // A credit returned this cycle is not usable until the next one: launch
  // looks only at the registered count.
  assign launch   = ~fifo_empty & (credit_cnt != '0);

  assign wr_word = {in_dest, in_is_tail, in_data};
  assign {rd_dest, rd_tail, rd_data} = rd_word;

  noc_flit_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (IN_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_noc),
    .rst     (rst_noc_sync),
    .push    (push),
    .pop     (launch),
    .wr_data (wr_word),
    .rd_data (rd_word),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Credit counter with saturation and sticky overflow detection.
  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      credit_cnt      <= MAX_CREDITS;
      credit_overflow <= 1'b0;
    end else begin
      case ({launch, credit_in})
        2'b10: credit_cnt <= credit_cnt - CW'(1);
        2'b01: begin
          if (credit_cnt == MAX_CREDITS) credit_overflow <= 1'b1;
          else                           credit_cnt <= credit_cnt + CW'(1);
        end
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

  // Link output register: fields load only on a launch and hold otherwise.
  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      send_out    <= 1'b0;
      data_out    <= '0;
      dest_out    <= '0;
      is_tail_out <= 1'b0;
    end else begin
      send_out <= launch;
      if (launch) begin
        data_out    <= rd_data;
        dest_out    <= rd_dest;
        is_tail_out <= rd_tail;
      end
    end
  end

  // Packet FSM, advanced by launched flits only.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch && !rd_tail) state_nxt = IN_PKT;
      IN_PKT:  if (launch && rd_tail)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) state <= IDLE;
    else              state <= state_nxt;
  end

  assign pkt_active = (state == IN_PKT);
  assign credits    = credit_cnt;

endmodule

// File: tb/tb_noc_credit_sender.sv
// Testbench for noc_credit_sender: directed scenarios followed by randomized
// traffic, all checked against a queue-based behavioural model.
module tb_noc_credit_sender;

  localparam int FW      = 32;
  localparam int DW      = 4;
  localparam int CRED_D  = 2;
  localparam int FIFO_D  = 2;
  localparam int CW      = $clog2(CRED_D + 1);
  localparam int WORD_W  = DW + 1 + FW;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] in_data;
  logic [DW-1:0] in_dest;
  logic          in_is_tail;
  logic [FW-1:0] data_out;
  logic [DW-1:0] dest_out;
  logic          is_tail_out;
  logic          send_out;
  logic          credit_in;
  logic [CW-1:0] credits;
  logic          pkt_active;
  logic          credit_overflow;

  always #5 clk = ~clk;

  noc_credit_sender #(
    .FLIT_WIDTH        (FW),
    .DEST_WIDTH        (DW),
    .FLIT_BUFFER_DEPTH (CRED_D),
    .IN_FIFO_DEPTH     (FIFO_D)
  ) dut (
    .clk_noc         (clk),
    .rst_noc_sync    (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_dest         (in_dest),
    .in_is_tail      (in_is_tail),
    .data_out        (data_out),
    .dest_out        (dest_out),
    .is_tail_out     (is_tail_out),
    .send_out        (send_out),
    .credit_in       (credit_in),
    .credits         (credits),
    .pkt_active      (pkt_active),
    .credit_overflow (credit_overflow)
  );

  // ---------------- scoreboard / behavioural model ----------------
  int errors = 0;
  int checks = 0;
  int send_cnt = 0;
  bit checking = 0;

  logic [WORD_W-1:0] exp_q[$];   // flits waiting in the staging FIFO
  int                m_credits = CRED_D;
  bit                m_in_pkt = 0;
  bit                m_ovf = 0;
  bit                m_send = 0;
  logic [FW-1:0]     m_data = '0;
  logic [DW-1:0]     m_dest = '0;
  logic              m_tail = 1'b0;
  bit                m_go;
  bit                m_acc;
  logic [WORD_W-1:0] m_word;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a flit leaves when something is queued and a credit is held; the
  // credit count is consumed/returned arithmetically and clamps at the buffer
  // depth; after sending a flit we are inside a packet unless it was a tail.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_credits = CRED_D;
      m_in_pkt  = 0;
      m_ovf     = 0;
      m_send    = 0;
      m_data    = '0;
      m_dest    = '0;
      m_tail    = 1'b0;
    end else begin
      m_go  = (exp_q.size() > 0) && (m_credits > 0);
      m_acc = in_valid && (exp_q.size() < FIFO_D);
      m_send = m_go;
      if (m_go) begin
        m_word = exp_q.pop_front();
        {m_dest, m_tail, m_data} = m_word;
        m_in_pkt = !m_tail;
      end
      if (m_acc) exp_q.push_back({in_dest, in_is_tail, in_data});
      m_credits = m_credits - int'(m_go) + int'(credit_in);
      if (m_credits > CRED_D) begin
        m_credits = CRED_D;
        m_ovf = 1;
      end
    end
  end

  // Compare process: every output, every cycle, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("send_out", send_out, m_send);
      chk("credits", credits, m_credits);
      chk("in_ready", in_ready, exp_q.size() < FIFO_D);
      chk("pkt_active", pkt_active, m_in_pkt);
      chk("credit_overflow", credit_overflow, m_ovf);
      chk("data_out", data_out, m_data);
      chk("dest_out", dest_out, m_dest);
      chk("is_tail_out", is_tail_out, m_tail);
      if (send_out) send_cnt++;
    end
  end

  // ---------------- driver tasks (start and end at a negedge) ----------------
  task automatic do_reset(input int cycles, input logic cred);
    rst = 1'b1;
    in_valid = 1'b0;
    credit_in = cred;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    credit_in = 1'b0;
  endtask

  task automatic push_flit(input logic [FW-1:0] d, input logic [DW-1:0] dst, input logic t);
    int n = 0;
    in_valid = 1'b1;
    in_data = d;
    in_dest = dst;
    in_is_tail = t;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_send();
    int n = 0;
    while (!send_out && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("send_seen", send_out, 1);
  endtask

  task automatic pulse_credit();
    credit_in = 1'b1;
    @(negedge clk);
    credit_in = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic tails [3] = '{1'b0, 1'b0, 1'b1};
  logic pkts  [3] = '{1'b1, 1'b1, 1'b0};
  int   base;
  int   pending;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_dest = '0;
    in_is_tail = 1'b0;
    credit_in = 1'b0;

    // Reset
    @(negedge clk);
    checking = 1;
    do_reset(2, 1'b0);
    chk("rst_credits", credits, 2);
    chk("rst_ready", in_ready, 1);
    chk("rst_send", send_out, 0);
    chk("rst_pkt", pkt_active, 0);
    chk("rst_ovf", credit_overflow, 0);

    // Credit exhaustion
    do_reset(2, 1'b0);
    base = send_cnt;
    for (int i = 0; i < 4; i++) push_flit(32'hA0 + i, DW'(i), 1'b1);
    repeat (3) @(negedge clk);
    chk("exh_sends", send_cnt - base, 2);
    chk("exh_credits", credits, 0);
    chk("exh_ready", in_ready, 0);
    pulse_credit();
    chk("exh_wait", send_out, 0);
    @(negedge clk);
    chk("exh_third", send_out, 1);
    chk("exh_third_data", data_out, 32'hA2);

    // Simultaneous launch and credit return with one credit held
    do_reset(2, 1'b0);
    in_valid = 1'b1; in_data = 32'hB0; in_dest = 4'h1; in_is_tail = 1'b1;
    @(negedge clk);
    in_data = 32'hB1;
    @(negedge clk);
    chk("sim_pre_credits", credits, 1);
    chk("sim_pre_send", send_out, 1);
    in_data = 32'hB2;
    credit_in = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    credit_in = 1'b0;
    chk("sim_credits", credits, 1);
    chk("sim_send", send_out, 1);
    chk("sim_data", data_out, 32'hB1);
    @(negedge clk);
    chk("sim_next_send", send_out, 1);
    chk("sim_next_data", data_out, 32'hB2);
    chk("sim_next_credits", credits, 0);

    // Packet FSM
    do_reset(2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      push_flit(32'hC0 + i, 4'h3, tails[i]);
      wait_send();
      chk("fsm_pkt", pkt_active, pkts[i]);
      pulse_credit();
    end
    push_flit(32'hC8, 4'h5, 1'b1);
    wait_send();
    chk("fsm_single_pkt", pkt_active, 0);
    pulse_credit();
    chk("fsm_single_after", pkt_active, 0);

    // Overflow: credits already full and idle
    chk("ovf_pre_credits", credits, 2);
    chk("ovf_pre", credit_overflow, 0);
    pulse_credit();
    chk("ovf_set", credit_overflow, 1);
    chk("ovf_credits", credits, 2);
    repeat (3) @(negedge clk);
    chk("ovf_sticky", credit_overflow, 1);

    // Reset mid-packet with two flits staged
    do_reset(2, 1'b0);
    for (int i = 0; i < 4; i++) push_flit(32'hD0 + i, 4'h7, 1'b0);
    repeat (2) @(negedge clk);
    chk("mr_pkt_before", pkt_active, 1);
    chk("mr_full_before", in_ready, 0);
    do_reset(2, 1'b1);
    chk("mr_credits", credits, 2);
    chk("mr_ready", in_ready, 1);
    chk("mr_pkt", pkt_active, 0);
    chk("mr_ovf", credit_overflow, 0);
    base = send_cnt;
    repeat (3) @(negedge clk);
    chk("mr_no_send", send_cnt - base, 0);
    push_flit(32'hE0, 4'h2, 1'b0);
    chk("mr_lat0", send_out, 0);
    @(negedge clk);
    chk("mr_lat1", send_out, 1);
    chk("mr_lat1_data", data_out, 32'hE0);

    // Randomized traffic with credits returned by a mock downstream buffer
    do_reset(2, 1'b0);
    pending = 0;
    for (int c = 0; c < 3000; c++) begin
      if (send_out) pending++;
      rst = 1'b0;
      credit_in = 1'b0;
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        pending = 0;
      end else if (pending > 0 && $urandom_range(0, 2) == 0) begin
        credit_in = 1'b1;
        pending--;
      end else if ($urandom_range(0, 299) == 0) begin
        credit_in = 1'b1;
      end
      in_valid = ($urandom_range(0, 99) < 60);
      in_data = $urandom;
      in_dest = DW'($urandom_range(0, 15));
      in_is_tail = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    credit_in = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
